// File: rtl/uii2c_slave_if.sv
// Register-file port of the uii2c target.
// The target drives address/data/strobes; the register file returns read data.
interface uii2c_slave_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport slave (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport master (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/uii2c_slave.sv
// I2C target mapping bus writes/reads onto a byte-wide register file.
// Filters SCL/SDA, tracks START/STOP, auto-increments an 8-bit pointer.
module uii2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         FILT_LEN = 3
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         iic_scl,
  inout  wire          iic_sda,
  output logic         iic_busy,
  output logic         sda_dg,
  uii2c_slave_if.slave rf
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CMAX = CW'(FILT_LEN - 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] WR_PTR    = 4'd3;
  localparam logic [3:0] WR_BYTE   = 4'd4;
  localparam logic [3:0] WR_ACK    = 4'd5;
  localparam logic [3:0] RD_BYTE   = 4'd6;
  localparam logic [3:0] RD_ACK    = 4'd7;
  localparam logic [3:0] WAIT_STOP = 4'd8;

  logic [1:0]    scl_s, sda_s;
  logic [CW-1:0] scl_c, sda_c;
  logic          scl_f, sda_f;
  logic          scl_p, sda_p;
  logic          scl_rise, scl_fall;
  logic          start, stop;

  logic [3:0] state;
  logic [3:0] bcnt;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic [7:0] wdata;
  logic       rw;
  logic       sda_oe;
  logic       busy;
  logic       we, re, ld;
  logic       ack_drv;
  logic       wr_pend;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_c <= '0;
      sda_c <= '0;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], iic_scl};
      sda_s <= {sda_s[0], iic_sda};
      scl_p <= scl_f;
      sda_p <= sda_f;
      if (scl_s[1] == scl_f) begin
        scl_c <= '0;
      end else if (scl_c == CMAX) begin
        scl_f <= scl_s[1];
        scl_c <= '0;
      end else begin
        scl_c <= scl_c + 1'b1;
      end
      if (sda_s[1] == sda_f) begin
        sda_c <= '0;
      end else if (sda_c == CMAX) begin
        sda_f <= sda_s[1];
        sda_c <= '0;
      end else begin
        sda_c <= sda_c + 1'b1;
      end
    end
  end

  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start = scl_f & scl_p & sda_p & ~sda_f;
  assign stop  = scl_f & scl_p & ~sda_p & sda_f;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      bcnt    <= '0;
      shreg   <= '0;
      ptr     <= '0;
      wdata   <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      we      <= 1'b0;
      re      <= 1'b0;
      ld      <= 1'b0;
      ack_drv <= 1'b0;
      wr_pend <= 1'b0;
    end else begin
      we <= 1'b0;
      re <= 1'b0;
      ld <= re;
      // read data lands two clocks after the strobe
      if (ld) begin
        shreg <= rf.reg_rdata;
        ptr   <= ptr + 1'b1;
      end
      if (we) ptr <= ptr + 1'b1;
      if (state == WR_ACK && ack_drv && wr_pend) begin
        we      <= 1'b1;
        wr_pend <= 1'b0;
      end
      unique case (1'b1)
        start, stop: begin
          state   <= start ? ADDR : IDLE;
          bcnt    <= '0;
          sda_oe  <= 1'b0;
          busy    <= 1'b0;
          ack_drv <= 1'b0;
          wr_pend <= 1'b0;
        end
        default: begin
          case (state)
            ADDR: if (scl_rise) begin
              shreg <= {shreg[6:0], sda_f};
              bcnt  <= bcnt + 1'b1;
              if (bcnt == 4'd7) begin
                rw      <= sda_f;
                ack_drv <= 1'b0;
                state   <= (shreg[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
              end
            end
            ADDR_ACK: begin
              if (scl_fall && !ack_drv) begin
                sda_oe  <= 1'b1;
                busy    <= 1'b1;
                ack_drv <= 1'b1;
              end else if (scl_rise && rw) begin
                re <= 1'b1;
              end else if (scl_fall && rw) begin
                state  <= RD_BYTE;
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
                bcnt   <= 4'd1;
              end else if (scl_fall) begin
                state  <= WR_PTR;
                sda_oe <= 1'b0;
                bcnt   <= '0;
              end
            end
            WR_PTR, WR_BYTE: if (scl_rise) begin
              shreg <= {shreg[6:0], sda_f};
              bcnt  <= bcnt + 1'b1;
              if (bcnt == 4'd7) begin
                state   <= WR_ACK;
                ack_drv <= 1'b0;
                if (state == WR_PTR) begin
                  ptr <= {shreg[6:0], sda_f};
                end else begin
                  wdata   <= {shreg[6:0], sda_f};
                  wr_pend <= 1'b1;
                end
              end
            end
            WR_ACK: if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_BYTE;
                bcnt   <= '0;
              end
            end
            RD_BYTE: if (scl_fall) begin
              if (bcnt == 4'd8) begin
                state  <= RD_ACK;
                sda_oe <= 1'b0;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
                bcnt   <= bcnt + 1'b1;
              end
            end
            RD_ACK: if (scl_rise) begin
              if (!sda_f) begin
                re    <= 1'b1;
                state <= RD_BYTE;
                bcnt  <= '0;
              end else begin
                state <= WAIT_STOP;
              end
            end
            IDLE, WAIT_STOP: ;
            default: state <= IDLE;
          endcase
        end
      endcase
    end
  end

  assign iic_sda      = sda_oe ? 1'b0 : 1'bz;
  assign iic_busy     = busy;
  assign sda_dg       = sda_f;
  assign rf.reg_addr  = ptr;
  assign rf.reg_wdata = wdata;
  assign rf.reg_we    = we;
  assign rf.reg_re    = re;

endmodule

// File: tb/tb_uii2c_slave.sv
// Bench for uii2c_slave: bit-banged I2C master, register file,
// and a transaction-level model of pointer/memory behaviour.
module tb_uii2c_slave;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  logic mem_clr = 1'b1;
  wire  sda;
  logic busy, sda_dg;

  uii2c_slave_if rf ();

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  uii2c_slave #(
    .DEV_ADDR(7'h3C),
    .FILT_LEN(3)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .iic_scl (scl),
    .iic_sda (sda),
    .iic_busy(busy),
    .sda_dg  (sda_dg),
    .rf      (rf.slave)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 73 + 29);
  endfunction

  logic [7:0] rf_mem [256];
  logic [7:0] rdq;
  logic [15:0] we_q [$];
  logic [7:0]  re_q [$];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) rf_mem[i] <= pat(i);
    end else if (rf.reg_we) begin
      rf_mem[rf.reg_addr] <= rf.reg_wdata;
    end
    if (rf.reg_re) rdq <= rf_mem[rf.reg_addr];
    if (rf.reg_we) we_q.push_back({rf.reg_addr, rf.reg_wdata});
    if (rf.reg_re) re_q.push_back(rf.reg_addr);
  end
  assign rf.reg_rdata = rdq;

  logic [7:0]  mdl [256];
  logic [7:0]  mptr;
  logic [15:0] exp_we [$];
  logic [7:0]  exp_re [$];
  logic [7:0]  wq [$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    tick(Q); m_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); m_low = 1'b1;
    tick(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); m_low = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); m_low = 1'b0;
    tick(Q);
  endtask

  task automatic bus_bit(input logic b, input logic g, output logic r);
    if (g) begin
      tick(2); scl = 1'b1;
      tick(2); scl = 1'b0;
      tick(Q - 4);
    end else begin
      tick(Q);
    end
    m_low = ~b;
    tick(Q); scl = 1'b1;
    tick(Q); r = sda;
    tick(Q); scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic g,
                         output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], g, r);
    bus_bit(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    bus_bit(nack, 1'b0, r);
  endtask

  task automatic cmp_q();
    chk("we_cnt", we_q.size(), exp_we.size());
    chk("re_cnt", re_q.size(), exp_re.size());
    for (int i = 0; i < we_q.size() && i < exp_we.size(); i++)
      chk("we_addr_data", we_q[i], exp_we[i]);
    for (int i = 0; i < re_q.size() && i < exp_re.size(); i++)
      chk("re_addr", re_q[i], exp_re[i]);
    we_q.delete();
    re_q.delete();
    exp_we.delete();
    exp_re.delete();
  endtask

  task automatic do_write(input logic [7:0] p, input logic g);
    logic a;
    bus_start();
    wr_byte(8'h78, g, a);
    chk("w_addr_ack", a, 0);
    wr_byte(p, g, a);
    chk("w_ptr_ack", a, 0);
    mptr = p;
    foreach (wq[i]) begin
      wr_byte(wq[i], g, a);
      chk("w_data_ack", a, 0);
      exp_we.push_back({mptr, wq[i]});
      mdl[mptr] = wq[i];
      mptr = mptr + 8'd1;
    end
    chk("w_busy", busy, 1);
    bus_stop();
    tick(4);
    chk("w_idle", busy, 0);
    cmp_q();
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] p,
                         input int n);
    logic a;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      wr_byte(8'h78, 1'b0, a);
      chk("r_waddr_ack", a, 0);
      wr_byte(p, 1'b0, a);
      chk("r_ptr_ack", a, 0);
      mptr = p;
      bus_start();
    end
    wr_byte(8'h79, 1'b0, a);
    chk("r_addr_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      exp_re.push_back(mptr);
      rd_byte(i == n - 1, d);
      chk("rd_data", d, mdl[mptr]);
      mptr = mptr + 8'd1;
    end
    chk("r_busy", busy, 1);
    bus_stop();
    tick(4);
    chk("r_idle", busy, 0);
    cmp_q();
  endtask

  task automatic do_wrong(input logic [7:0] ab);
    logic a;
    bus_start();
    wr_byte(ab, 1'b0, a);
    chk("bad_addr_nack", a, 1);
    chk("bad_busy", busy, 0);
    wr_byte(8'h00, 1'b0, a);
    chk("bad_data_nack", a, 1);
    bus_stop();
    tick(4);
    cmp_q();
  endtask

  task automatic rst_outs(input string tag);
    chk({tag, "_sda"}, sda, 1);
    chk({tag, "_addr"}, rf.reg_addr, 0);
    chk({tag, "_wdata"}, rf.reg_wdata, 0);
    chk({tag, "_we"}, rf.reg_we, 0);
    chk({tag, "_re"}, rf.reg_re, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sda_dg"}, sda_dg, 1);
  endtask

  initial begin
    logic r, a, ok;
    logic [7:0] b;
    logic [6:0] wa;
    int kind, n;
    for (int i = 0; i < 256; i++) mdl[i] = pat(i);
    mptr = 8'h00;
    tick(5);
    rst_outs("reset");
    mem_clr = 1'b0;
    rstn = 1'b1;
    tick(10);

    wq.delete(); wq.push_back(8'hAB); wq.push_back(8'hCD);
    do_write(8'h10, 1'b0);

    wq.delete(); wq.push_back(8'h5A); wq.push_back(8'hC3);
    do_write(8'h20, 1'b0);
    do_read(1'b1, 8'h20, 2);

    do_wrong(8'h7A << 1);
    do_wrong(8'h7A);

    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    do_write(8'hFF, 1'b0);

    bus_start();
    wr_byte(8'h78, 1'b0, a);
    chk("abort_addr_ack", a, 0);
    wr_byte(8'h40, 1'b0, a);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0, r);
    bus_stop();
    tick(4);
    chk("abort_sda", sda, 1);
    chk("abort_busy", busy, 0);
    mptr = 8'h40;
    cmp_q();
    do_read(1'b0, 8'h00, 1);

    bus_start();
    b = 8'h78;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], 1'b0, r);
    tick(Q);
    m_low = 1'b0;
    tick(2);
    chk("ack_driven", sda, 0);
    rstn = 1'b0;
    tick(1);
    rst_outs("mid_reset");
    rstn = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(4 * Q);
    mptr = 8'h00;
    do_read(1'b0, 8'h00, 2);

    ok = 1'b1;
    m_low = 1'b1;
    tick(2);
    m_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (sda_dg !== 1'b1) ok = 1'b0;
    end
    chk("sda_glitch", ok, 1);
    wq.delete(); wq.push_back(8'h96); wq.push_back(8'h3E);
    do_write(8'h80, 1'b1);
    do_read(1'b1, 8'h80, 2);

    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      case (kind)
        0: begin
          wq.delete();
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          do_write(8'($urandom), 1'b0);
        end
        1: do_read(1'b1, 8'($urandom), n);
        2: do_read(1'b0, 8'h00, n);
        default: begin
          wa = 7'($urandom);
          if (wa == 7'h3C) wa = 7'h3D;
          do_wrong({wa, 1'($urandom)});
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
